// File: rtl/rcv_pkg.sv
// Shared types for the receive-side sequencer.
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD,
        WAIT_HIGH
    } rcv_state_t;

endpackage

// File: rtl/rcv_bit_timer.sv
// Bit-period timer with programmable rollover, plus the received-bit counter.
module rcv_bit_timer #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8,
    localparam int TW = $clog2(CLKS_PER_BIT),
    localparam int BW = $clog2(NUM_DATA_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [TW-1:0] rollover_val,
    input  logic          bit_clear,
    input  logic          bit_inc,
    output logic [TW-1:0] count,
    output logic          rollover_flag,
    output logic [BW-1:0] bit_count
);

    logic [TW-1:0] r_count;
    logic [BW-1:0] r_bit_count;

    assign rollover_flag = enable && (r_count == rollover_val);
    assign count         = r_count;
    assign bit_count     = r_bit_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear || rollover_flag) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_count <= '0;
        end else if (bit_clear) begin
            r_bit_count <= '0;
        end else if (bit_inc) begin
            r_bit_count <= r_bit_count + 1'b1;
        end
    end

endmodule

// File: rtl/rcv_ctrl.sv
// Receive sequencer: synchronizes the line, times each bit, strobes the external
// shift register and latches the finished byte behind a ready/read handshake.
module rcv_ctrl
    import rcv_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     serial_in,
    input  logic [NUM_DATA_BITS-1:0] packet_data,
    input  logic                     data_read,
    output logic                     serial_sync,
    output logic                     shift_enable,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     data_ready,
    output logic                     framing_error,
    output logic                     overrun_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_DATA_BITS - 1);

    rcv_state_t              r_state, w_next_state;
    logic                    r_sync1, r_sync2, r_prev;
    logic                    r_shift_en, r_ready, r_fe, r_oe;
    logic [NUM_DATA_BITS-1:0] r_rx_data;

    logic                    w_start_edge;
    logic                    w_tmr_clear, w_tmr_en, w_roll;
    logic [TW-1:0]           w_roll_val, w_tmr_count;
    logic                    w_bit_clear, w_bit_inc;
    logic [BW-1:0]           w_bit_count;
    logic                    w_shift_set, w_fe_set, w_fe_clr, w_load;

    rcv_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .NUM_DATA_BITS(NUM_DATA_BITS)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (w_tmr_clear),
        .enable       (w_tmr_en),
        .rollover_val (w_roll_val),
        .bit_clear    (w_bit_clear),
        .bit_inc      (w_bit_inc),
        .count        (w_tmr_count),
        .rollover_flag(w_roll),
        .bit_count    (w_bit_count)
    );

    // r_prev trails serial_sync by one clock so a falling line is seen for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign serial_sync  = r_sync2;
    assign w_start_edge = r_prev && !r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_tmr_clear  = 1'b0;
        w_tmr_en     = 1'b0;
        w_roll_val   = FULL_BIT;
        w_bit_clear  = 1'b0;
        w_bit_inc    = 1'b0;
        w_shift_set  = 1'b0;
        w_fe_set     = 1'b0;
        w_fe_clr     = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_tmr_clear  = 1'b1;
                    w_fe_clr     = 1'b1;
                    w_next_state = START_CHK;
                end
            end
            START_CHK: begin
                w_tmr_en   = 1'b1;
                w_roll_val = HALF_BIT;
                if (w_roll) begin
                    if (!r_sync2) begin
                        w_tmr_clear  = 1'b1;
                        w_bit_clear  = 1'b1;
                        w_next_state = DATA;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            DATA: begin
                w_tmr_en = 1'b1;
                if (w_roll) begin
                    w_shift_set = 1'b1;
                    w_bit_inc   = 1'b1;
                    if (w_bit_count == LAST_BIT) w_next_state = STOP;
                end
            end
            STOP: begin
                w_tmr_en = 1'b1;
                if (w_roll) begin
                    w_fe_set     = !r_sync2;
                    w_next_state = r_sync2 ? LOAD : WAIT_HIGH;
                end
            end
            LOAD: begin
                w_load       = 1'b1;
                w_next_state = IDLE;
            end
            WAIT_HIGH: begin
                if (r_sync2) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A read coinciding with LOAD acknowledges the old byte, so no overrun is flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_en <= 1'b0;
            r_rx_data  <= '1;
            r_ready    <= 1'b0;
            r_fe       <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            r_shift_en <= w_shift_set;
            if (w_fe_clr)      r_fe <= 1'b0;
            else if (w_fe_set) r_fe <= 1'b1;
            if (w_load) begin
                r_rx_data <= packet_data;
                r_ready   <= 1'b1;
                r_oe      <= r_ready && !data_read;
            end else if (data_read) begin
                r_ready <= 1'b0;
                r_oe    <= 1'b0;
            end
        end
    end

    assign shift_enable  = r_shift_en;
    assign rx_data       = r_rx_data;
    assign data_ready    = r_ready;
    assign framing_error = r_fe;
    assign overrun_error = r_oe;

endmodule

// File: tb/tb_rcv_ctrl.sv
// Directed and randomized frames against a frame-level model of the receiver.
module tb_rcv_ctrl;
    import rcv_pkg::*;

    localparam int NB  = 8;
    localparam int CPB = 10;

    logic          clk = 1'b0;
    logic          rst, serial_in, data_read;
    logic [NB-1:0] packet_data, rx_data;
    logic          serial_sync, shift_enable, data_ready, framing_error, overrun_error;
    logic [NB-1:0] shreg;

    int tests = 0;
    int fails = 0;
    int cyc = 0, pulse_cnt = 0, gap_err = 0, last_pulse = 0;

    logic [NB-1:0] exp_data;
    logic          exp_ready, exp_fe, exp_oe;

    always #5 clk = ~clk;

    rcv_ctrl #(.NUM_DATA_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .packet_data  (packet_data),
        .data_read    (data_read),
        .serial_sync  (serial_sync),
        .shift_enable (shift_enable),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    // LSB-first serial-to-parallel register attached to the receiver
    always @(posedge clk or posedge rst) begin
        if (rst)               shreg <= '1;
        else if (shift_enable) shreg <= {serial_sync, shreg[NB-1:1]};
    end
    assign packet_data = shreg;

    // Pulses inside a frame must be one cycle wide and exactly CPB apart
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (shift_enable) begin
            if (pulse_cnt > 0 && (cyc - last_pulse) < 25 && (cyc - last_pulse) != CPB)
                gap_err <= gap_err + 1;
            pulse_cnt  <= pulse_cnt + 1;
            last_pulse <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'(exp_data));
        chk({tag, "_ready"}, 32'(data_ready), 32'(exp_ready));
        chk({tag, "_ferr"}, 32'(framing_error), 32'(exp_fe));
        chk({tag, "_oerr"}, 32'(overrun_error), 32'(exp_oe));
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        exp_ready = 1'b0;
        exp_oe    = 1'b0;
    endtask

    // Reference: a completed frame either loads the byte or only flags framing
    task automatic model_frame(input logic [NB-1:0] b, input bit stop, input bit ack_load);
        exp_fe = 1'b0;
        if (!stop) begin
            exp_fe = 1'b1;
        end else begin
            exp_oe    = ack_load ? 1'b0 : (exp_oe | exp_ready);
            exp_ready = 1'b1;
            exp_data  = b;
        end
    endtask

    task automatic send_frame(input logic [NB-1:0] b, input bit stop, input bit ack_load,
                              input bit chk_fe_clear, input string tag);
        int pc0;
        pc0 = pulse_cnt;
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            serial_in = b[i];
            repeat (CPB) @(negedge clk);
            if (chk_fe_clear && i == 1) chk({tag, "_ferr_cleared"}, 32'(framing_error), 32'd0);
        end
        serial_in = stop;
        for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            data_read = ack_load && (dut.r_state == LOAD);
        end
        data_read = 1'b0;
        chk({tag, "_pulses"}, 32'(pulse_cnt - pc0), 32'(NB));
        model_frame(b, stop, ack_load);
    endtask

    initial begin
        logic [NB-1:0] b;
        int            pc0, mode;
        bit            stop;

        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
        exp_data = '1; exp_ready = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_serial_sync", 32'(serial_sync), 32'd1);
        chk("rst_shift_enable", 32'(shift_enable), 32'd0);
        check_all("rst");
        rst = 1'b0;

        pc0 = pulse_cnt;
        idle(100);
        chk("idle_pulses", 32'(pulse_cnt - pc0), 32'd0);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5");
        idle(5);
        check_all("a5");

        pc0 = pulse_cnt;
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        chk("glitch_pulses", 32'(pulse_cnt - pc0), 32'd0);
        chk("glitch_state", 32'(dut.r_state), 32'(IDLE));
        check_all("glitch");

        ack();
        check_all("ack_a5");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "3c");
        repeat (30) @(negedge clk);
        chk("3c_wait_high", 32'(dut.r_state), 32'(WAIT_HIGH));
        check_all("3c");
        idle(10);
        chk("3c_back_idle", 32'(dut.r_state), 32'(IDLE));

        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b1, "after_ferr");
        idle(5);
        check_all("after_ferr");

        ack();
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, "x11");
        idle(5);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, "x22");
        idle(5);
        check_all("overrun");
        ack();
        check_all("overrun_ack");

        send_frame(8'h66, 1'b1, 1'b0, 1'b0, "pre_coinc");
        send_frame(8'h99, 1'b1, 1'b1, 1'b0, "coinc");
        idle(5);
        check_all("coinc");

        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            mode = $urandom_range(0, 2);
            stop = ($urandom_range(0, 3) != 0);
            if (mode == 0) ack();
            send_frame(b, stop, mode == 2, 1'b0, "rnd");
            idle(5);
            check_all("rnd");
        end

        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_serial_sync", 32'(serial_sync), 32'd1);
        chk("midrst_shift_enable", 32'(shift_enable), 32'd0);
        chk("midrst_state", 32'(dut.r_state), 32'(IDLE));
        exp_data = '1; exp_ready = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0;
        check_all("midrst");
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, "x5a");
        idle(5);
        check_all("x5a");

        chk("pulse_spacing", 32'(gap_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rcv_ctrl.md
# rcv_ctrl

Receive-side sequencer for the serial link. It owns the bit timing and drives the flex serial-to-parallel shift register, which is instantiated beside it with SHIFT_MSB = 0 for LSB-first data. It detects the start bit, pulses the register's shift enable at each data-bit centre and checks the stop bit. It then captures the assembled byte into a holding buffer behind a ready/read handshake with framing and overrun error flags.

## Interface
- NUM_DATA_BITS, default 8: data bits per frame; must be ≥ 2.
- CLKS_PER_BIT, default 10: clocks per bit period; must be ≥ 4.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset; one clock, asynchronous and active-high.
- serial_in  input  1  raw line (idle = 1); asynchronous to clk.
- packet_data  input  NUM_DATA_BITS  parallel_out of the external shift register.
- data_read  input  1  consumer acknowledge; one-cycle pulse.
- serial_sync  output  1  synchronized line; feeds the shift register serial_in.
- shift_enable  output  1  one-cycle pulse to the shift register.
- rx_data  output  NUM_DATA_BITS  holding buffer.
- data_ready  output  1  rx_data holds an unread byte.
- framing_error  output  1  the last frame had stop bit = 0.
- overrun_error  output  1  a byte was loaded while data_ready was still set.

## Operation
- serial_in passes through a 2-flop synchronizer, giving serial_sync. A third flop holds the previous sample. A start edge is previous = 1 and serial_sync = 0.
- States:
  - IDLE: on a start edge, clear the bit timer, clear framing_error and go to START_CHK.
  - START_CHK: when the timer reaches CLKS_PER_BIT/2 − 1 (integer divide), sample serial_sync.
    - 0: reset the timer and go to DATA with bit count = 0.
    - 1: glitch; return to IDLE with no flags changed.
  - DATA: when the timer reaches CLKS_PER_BIT − 1, assert shift_enable for 1 cycle, wrap the timer to 0 and increment the bit count. After the NUM_DATA_BITS-th pulse, go to STOP.
  - STOP: when the timer reaches CLKS_PER_BIT − 1, sample serial_sync.
    - 1: go to LOAD.
    - 0: set framing_error and go to WAIT_HIGH.
  - LOAD: one cycle. Set rx_data ← packet_data and data_ready ← 1. Set overrun_error if data_ready was already 1 and data_read is not asserted this cycle. Return to IDLE.
  - WAIT_HIGH: remain until serial_sync = 1, then go to IDLE. A line held low never produces a frame.
- data_read clears data_ready and overrun_error on the next edge.
  - If LOAD and data_read coincide, data_ready stays 1 and overrun_error is not set.
  - data_read while data_ready = 0 has no effect.
- framing_error is sticky until the next accepted start edge. A framing error never modifies rx_data or data_ready.
- The bit timer is ceil(log2(CLKS_PER_BIT)) wide and wraps to 0 exactly at CLKS_PER_BIT − 1. The bit counter is ceil(log2(NUM_DATA_BITS+1)) wide.

## Timing
- Reset values:
  - Synchronizer flops and serial_sync: 1.
  - rx_data: all ones (matches the shift register reset).
  - shift_enable, data_ready, framing_error, overrun_error: 0.
  - State: IDLE.
- rst mid-frame aborts immediately to IDLE with all outputs at their reset values.
- serial_in → serial_sync latency is 2 clocks. Start edge → START_CHK is 1 clock.
- Each shift_enable pulse is 1 cycle wide; consecutive pulses are exactly CLKS_PER_BIT cycles apart.
  - The first pulse comes CLKS_PER_BIT/2 + CLKS_PER_BIT cycles after entry to START_CHK.
  - The register shifts on the same edge that ends the pulse.
- The stop sample comes CLKS_PER_BIT cycles after the last shift_enable. data_ready rises 2 cycles after the stop sample (one cycle to enter LOAD, then the LOAD-cycle update).
- A start edge is only accepted in IDLE. Back-to-back frames are supported because LOAD returns to IDLE inside the stop bit.

## Structure
- Package rcv_pkg holds the state enum type rcv_state_t (IDLE, START_CHK, DATA, STOP, LOAD, WAIT_HIGH).
- One sub-module, rcv_bit_timer, holds the bit timer and bit counter.
  - Inputs: clear, enable, rollover value.
  - Outputs: count and rollover_flag.
- The FSM, synchronizer and buffer/flag logic stay in rcv_ctrl.
- The flex shift register is instantiated one level up, not inside this block.

## Test plan
All scenarios use CLKS_PER_BIT = 10 and NUM_DATA_BITS = 8, with the shift register attached.
- After rst, all outputs are at their reset values. Idle line: no shift_enable for 100 cycles.
- Send frame 0xA5 (LSB first) with stop = 1:
  - exactly 8 shift_enable pulses, 10 cycles apart;
  - rx_data = 0xA5, data_ready = 1, both error flags 0.
- Drive a low glitch of 3 cycles: return to IDLE, no shift_enable, all flags unchanged.
- Send 0x3C with stop = 0:
  - framing_error = 1, data_ready stays 0, rx_data unchanged;
  - state stays WAIT_HIGH until the line returns high;
  - the next good frame clears framing_error at its start edge.
- Send 0x11 then 0x22 without data_read: overrun_error = 1 and rx_data = 0x22. A data_read pulse then clears data_ready and overrun_error on the next cycle.
- Assert rst mid-DATA: outputs are at reset values immediately. The next frame 0x5A is received correctly.
